// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the dmem load/store sequencer.
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int LANE_BITS = 2;

  // Misaligned half/word accesses and the reserved size code are rejected.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [LANE_BITS-1:0] offset);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return offset[0];
      SZ_W:    return offset != '0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake between the pipeline and the load/store sequencer.
interface dmem_lsu_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: sub-word load extract/extend and sub-word store merge.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0]          word,
  input  logic [LANE_BITS-1:0] offset,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [31:0]          wdata,
  output logic [31:0]          load_data,
  output logic [31:0]          merged
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    byte_sel  = word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_B: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        merged    = word;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        merged    = word;
        merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer driving dmem on behalf of the pipeline; one request in flight.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_lsu_if.slave         bus,
  output logic [ADDR_W-1:0] readAddress,
  input  logic [DATA_W-1:0] readData,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              mem_we
);
  state_t            state;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W+1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  dmem_lane_align u_align (
    .word      (readData),
    .offset    (r_addr[LANE_BITS-1:0]),
    .size      (r_size),
    .sign_ext  (r_signed),
    .wdata     (r_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      r_size         <= SZ_B;
      r_signed       <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      readAddress    <= '0;
      writeAddress   <= '0;
      writeData      <= '0;
      mem_we         <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every branch sees pre-edge values.
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_size        <= bus.req_size;
            r_signed      <= bus.req_signed;
            r_addr        <= bus.req_addr;
            r_wdata       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (access_err(bus.req_size, bus.req_addr[LANE_BITS-1:0])) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (!bus.req_write) begin
              state       <= RD;
              readAddress <= bus.req_addr[ADDR_W+1:LANE_BITS];
            end else if (bus.req_size == SZ_W) begin
              state        <= WR;
              writeAddress <= bus.req_addr[ADDR_W+1:LANE_BITS];
              writeData    <= bus.req_wdata;
              mem_we       <= 1'b1;
            end else begin
              state       <= RMW_RD;
              readAddress <= bus.req_addr[ADDR_W+1:LANE_BITS];
            end
          end
        end
        RD: begin
          state          <= RESP;
          readAddress    <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= load_data;
          bus.resp_err   <= 1'b0;
        end
        RMW_RD: begin
          state        <= WR;
          readAddress  <= '0;
          writeAddress <= r_addr[ADDR_W+1:LANE_BITS];
          writeData    <= merged;
          mem_we       <= 1'b1;
        end
        WR: begin
          state          <= RESP;
          writeAddress   <= '0;
          writeData      <= '0;
          mem_we         <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
        end
        RESP: begin
          // Acceptance resumes only from IDLE, one cycle after the response handshake.
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a behavioural dmem model.
module tb_dmem_lsu;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] readAddress;
  logic [DATA_W-1:0] readData;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;
  logic              mem_we;

  logic [31:0] mem [512] = '{default: 32'h0};

  int total = 0;
  int bad   = 0;

  int          r_cyc;
  logic [31:0] r_data;
  logic [31:0] r_err;
  int          we_cnt;
  int          we_cyc;
  logic [31:0] we_addr;
  logic [31:0] we_data;
  logic [31:0] timed_out;

  dmem_lsu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .readAddress  (readAddress),
    .readData     (readData),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .mem_we       (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign readData = mem[readAddress];
  always @(posedge clk) if (mem_we) mem[writeAddress] <= writeData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request through its acceptance edge; returns in cycle 1.
  task automatic start_req(input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [10:0] addr, input logic [31:0] wd);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("req_ready_before_issue", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles from acceptance to resp_valid, recording any dmem write pulse.
  task automatic wait_resp();
    r_cyc     = 1;
    we_cnt    = 0;
    we_cyc    = 0;
    we_addr   = '0;
    we_data   = '0;
    timed_out = 32'd1;
    for (int i = 0; i < 10; i++) begin
      if (mem_we === 1'b1) begin
        we_cnt++;
        we_cyc  = r_cyc;
        we_addr = {23'b0, writeAddress};
        we_data = writeData;
      end
      if (bus.resp_valid === 1'b1) begin
        timed_out = 32'd0;
        break;
      end
      tick();
      r_cyc++;
    end
    check("resp_timeout", timed_out, 32'd0);
    r_data = bus.resp_rdata;
    r_err  = {31'b0, bus.resp_err};
  endtask

  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [10:0] addr, input logic [31:0] wd);
    start_req(wr, sz, sgn, addr, wd);
    wait_resp();
    finish_resp();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    #12;
    check("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    check("rst_dmem_outs",  {readAddress, writeAddress, 13'b0, mem_we}, 32'd0);
    check("rst_wdata",      writeData,               32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Word store 12345 to byte 40, then load it back.
    do_req(1'b1, 2'd2, 1'b0, 11'd40, 32'd12345);
    check("wst_we_count", we_cnt, 1);
    check("wst_we_cycle", we_cyc, 1);
    check("wst_we_addr",  we_addr, 32'd10);
    check("wst_we_data",  we_data, 32'd12345);
    check("wst_resp_cyc", r_cyc, 2);
    check("wst_rdata",    r_data, 32'd0);
    check("wst_err",      r_err, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 11'd40, 32'd0);
    check("wld_resp_cyc", r_cyc, 2);
    check("wld_rdata",    r_data, 32'd12345);
    check("wld_we_count", we_cnt, 0);

    // Byte RMW into lane 2; upper wdata bits must be ignored.
    do_req(1'b1, 2'd2, 1'b0, 11'd44, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 11'd46, 32'hFFFFFFAB);
    check("bst_we_cycle", we_cyc, 2);
    check("bst_we_count", we_cnt, 1);
    check("bst_we_addr",  we_addr, 32'd11);
    check("bst_we_data",  we_data, 32'h11AB3344);
    check("bst_resp_cyc", r_cyc, 3);
    do_req(1'b0, 2'd2, 1'b0, 11'd44, 32'd0);
    check("bst_readback", r_data, 32'h11AB3344);

    // Extension cases on 0x0000F080 at byte 48.
    do_req(1'b1, 2'd2, 1'b0, 11'd48, 32'h0000F080);
    do_req(1'b0, 2'd0, 1'b1, 11'd48, 32'd0);
    check("ld_b_signed",   r_data, 32'hFFFFFF80);
    do_req(1'b0, 2'd1, 1'b0, 11'd48, 32'd0);
    check("ld_h_unsigned", r_data, 32'h0000F080);
    do_req(1'b0, 2'd1, 1'b1, 11'd48, 32'd0);
    check("ld_h_signed",   r_data, 32'hFFFFF080);
    do_req(1'b0, 2'd0, 1'b0, 11'd49, 32'd0);
    check("ld_b1_unsigned", r_data, 32'h000000F0);
    do_req(1'b1, 2'd1, 1'b0, 11'd50, 32'hCAFE1234);
    check("hst_we_data",   we_data, 32'h1234F080);
    do_req(1'b0, 2'd1, 1'b1, 11'd50, 32'd0);
    check("ld_h2_signed",  r_data, 32'h00001234);

    // Error paths: no dmem access, response in cycle 1.
    do_req(1'b0, 2'd1, 1'b0, 11'd41, 32'd0);
    check("err_h_cyc",   r_cyc, 1);
    check("err_h_flag",  r_err, 32'd1);
    check("err_h_rdata", r_data, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 11'd42, 32'hDEADBEEF);
    check("err_w_cyc",   r_cyc, 1);
    check("err_w_flag",  r_err, 32'd1);
    check("err_w_we",    we_cnt, 0);
    do_req(1'b0, 2'd3, 1'b0, 11'd40, 32'd0);
    check("err_sz3_flag", r_err, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 11'd40, 32'd0);
    check("err_mem_kept", r_data, 32'd12345);

    // Highest byte address maps to the last word.
    do_req(1'b1, 2'd0, 1'b0, 11'h7FF, 32'h0000005A);
    check("top_we_addr", we_addr, 32'd511);
    check("top_we_data", we_data, 32'h5A000000);

    // Response backpressure with a competing request held on the bus.
    start_req(1'b0, 2'd2, 1'b0, 11'd44, 32'd0);
    wait_resp();
    check("bp_resp_cyc", r_cyc, 2);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 11'd48;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("bp_rdata", bus.resp_rdata, 32'h11AB3344);
      check("bp_ready", {31'b0, bus.req_ready}, 32'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("bp_idle_ready", {31'b0, bus.req_ready},  32'd1);
    check("bp_idle_valid", {31'b0, bus.resp_valid}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    check("bp_next_accepted", {31'b0, bus.req_ready}, 32'd0);
    wait_resp();
    finish_resp();
    check("bp_next_rdata", r_data, 32'h1234F080);

    // Reset asserted during the WR cycle of a byte store.
    do_req(1'b1, 2'd2, 1'b0, 11'd52, 32'h55667788);
    start_req(1'b1, 2'd0, 1'b0, 11'd53, 32'h00000099);
    tick();
    check("mid_we_high", {31'b0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_we_fall",    {31'b0, mem_we}, 32'd0);
    check("mid_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("mid_dmem_outs",  {readAddress, writeAddress, 14'b0}, 32'd0);
    check("mid_wdata",      writeData, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    do_req(1'b0, 2'd2, 1'b0, 11'd52, 32'd0);
    check("mid_mem_kept", r_data, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
